bit_serial_adder: RTL and testbench

BIT_SERIAL_ADDER -- requirements
Module: bit_serial_adder

---
 rtl/bit_serial_adder.sv | 178 +++++++++++++++++
 tb/tb_bit_serial_adder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : bit_serial_adder
// Description : Adds two WIDTH-bit operands plus a carry-in using a single
//               1-bit full-adder cell that is reused once per clock cycle.
//               One result takes WIDTH cycles. Valid/ready handshake on both
//               sides.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH      operand / sum width in bits (2..64), default 16
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operands and c_in valid
//   in_ready   block accepts operands (high only in IDLE)
//   add_1      operand 1
//   add_2      operand 2
//   c_in       initial carry
//   out_valid  sum / c_out valid (high only in DONE)
//   out_ready  consumer takes the result
//   sum        registered result, modulo 2^WIDTH
//   c_out      registered carry out of bit WIDTH-1
//   ovf        registered signed overflow (only when BIT_SERIAL_ADDER_OVF_EN
//              is defined)
// Configuration macro
//   BIT_SERIAL_ADDER_OVF_EN  adds the ovf output and its logic
// ============================================================================
module bit_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] add_1,
  input  logic [WIDTH-1:0] add_2,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef BIT_SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic               r_c_out;
  logic [c_CNT_W-1:0] r_cnt;
  logic               w_last;
  logic               w_fa_sum;
  logic               w_fa_carry;

  // The one and only full-adder cell: operand LSBs plus the carry FF.
  assign w_fa_sum   = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_fa_carry = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);

  assign w_last = (r_cnt == c_CNT_LAST);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: operand shifters, sum shifter, carry FF, bit counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_c_out <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= add_1;
            r_b     <= add_2;
            r_carry <= c_in;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_a     <= {1'b0, r_a[WIDTH-1:1]};
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          // Right shift: after WIDTH steps the first computed bit sits at bit 0.
          r_sum   <= {w_fa_sum, r_sum[WIDTH-1:1]};
          r_carry <= w_fa_carry;
          r_cnt   <= r_cnt + c_CNT_ONE;
          // c_out keeps the previous result until the final bit is computed.
          if (w_last) begin
            r_c_out <= w_fa_carry;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef BIT_SERIAL_ADDER_OVF_EN
  logic r_ovf;

  // On the last step the carry FF holds the carry into the MSB and the cell
  // produces the carry out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if ((r_state == RUN) && w_last) begin
      r_ovf <= r_carry ^ w_fa_carry;
    end
  end

  assign ovf = r_ovf;
`endif

  assign sum   = r_sum;
  assign c_out = r_c_out;

endmodule
`default_nettype wire

// File: tb/tb_bit_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_serial_adder
// Description : Self-checking bench for bit_serial_adder at WIDTH=8. Directed
//               cases, hold/stall, in_valid during RUN, mid-RUN reset and
//               random back-to-back traffic against an arithmetic model.
//               Honours BIT_SERIAL_ADDER_OVF_EN for the ovf port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] add_1;
  logic [W-1:0] add_2;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
`ifdef BIT_SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .add_1     (add_1),
    .add_2     (add_2),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out)
`ifdef BIT_SERIAL_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } result_t;

  // Reference: plain integer addition, signed overflow from operand signs.
  function automatic result_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic ci);
    result_t r;
    int unsigned t;
    t    = int'(a) + int'(b) + int'(ci);
    r.s  = W'(t % (1 << W));
    r.co = (t >= (1 << W));
    r.ov = (a[W-1] == b[W-1]) && (r.s[W-1] != a[W-1]);
    return r;
  endfunction

  task automatic check_ovf(input string tag, input logic exp);
`ifdef BIT_SERIAL_ADDER_OVF_EN
    check(tag, 64'(ovf), 64'(exp));
`else
    if (exp === 1'bx) $display("note: %s", tag);
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  64'(in_ready),  64'd1);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_sum"},       64'(sum),       64'd0);
    check({tag, "_c_out"},     64'(c_out),     64'd0);
    check_ovf({tag, "_ovf"}, 1'b0);
  endtask

  // One full transaction from IDLE. Called at posedge+1.
  task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input logic [W-1:0] exp_s, input logic exp_co, input logic exp_ov,
                         input int hold, input bit pulse);
    int lat;
    logic [W-1:0] held_s;
    logic         held_co;
    check("start_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    add_1    = a;
    add_2    = b;
    c_in     = ci;
    tick();
    in_valid = 1'b0;
    add_1    = 8'($urandom);
    add_2    = 8'($urandom);
    c_in     = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 64) begin
      if (pulse && lat == 2) begin
        check("run_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b1;
        add_1    = 8'($urandom);
        add_2    = 8'($urandom);
        c_in     = 1'($urandom);
      end
      if (pulse && lat == 5) in_valid = 1'b0;
      tick();
      lat++;
    end
    in_valid = 1'b0;
    check("latency", 64'(lat), 64'(W));
    check("sum",     64'(sum),   64'(exp_s));
    check("c_out",   64'(c_out), 64'(exp_co));
    check_ovf("ovf", exp_ov);
    held_s  = sum;
    held_co = c_out;
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      tick();
      check("hold_out_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready",  64'(in_ready),  64'd0);
      check("hold_sum",       64'(sum),       64'(held_s));
      check("hold_c_out",     64'(c_out),     64'(held_co));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release_out_valid", 64'(out_valid), 64'd0);
    check("release_in_ready",  64'(in_ready),  64'd1);
    check("idle_keeps_sum",    64'(sum),       64'(exp_s));
    if (pulse) begin
      repeat (W + 3) tick();
      check("no_second_result", 64'(out_valid), 64'd0);
    end
  endtask

  result_t q[$];

  initial begin
    result_t exp_r;
    result_t got_r;
    int cyc;
    int done_cnt;
    bit accept;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    add_1     = '0;
    add_2     = '0;
    c_in      = 1'b0;
    #1;
    check_reset_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
    check("idle_after_reset", 64'(in_ready), 64'd1);

    // Directed cases (expected values from the arithmetic by hand).
    run_txn(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1, 0, 1'b0);
    run_txn(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0);
    run_txn(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 0, 1'b0);
    // Stall in DONE for 5 cycles.
    run_txn(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 5, 1'b0);
    // in_valid pulsed during RUN must be ignored.
    run_txn(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, 0, 1'b1);

    // Reset between edges after 4 RUN cycles.
    in_valid = 1'b1;
    add_1    = 8'hAB;
    add_2    = 8'h11;
    c_in     = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    tick();
    check_reset_outputs("midrun_reset_held");
    #2;
    rst_n = 1'b1;
    tick();
    check("after_abort_out_valid", 64'(out_valid), 64'd0);
    run_txn(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 0, 1'b0);

    // Random back-to-back traffic with random consumer backpressure.
    cyc      = 0;
    done_cnt = 0;
    while (done_cnt < 1000 && cyc < 40000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      add_1     = 8'($urandom);
      add_2     = 8'($urandom);
      c_in      = 1'($urandom);
      out_ready = 1'($urandom);
      accept    = in_valid && in_ready;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("rand_spurious_result", 64'd1, 64'd0);
        end else begin
          exp_r = q.pop_front();
          got_r.s  = sum;
          got_r.co = c_out;
          check("rand_sum",   64'(got_r.s),  64'(exp_r.s));
          check("rand_c_out", 64'(got_r.co), 64'(exp_r.co));
          check_ovf("rand_ovf", exp_r.ov);
        end
        done_cnt++;
      end
      if (accept) q.push_back(model(add_1, add_2, c_in));
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("rand_completed", 64'(done_cnt), 64'd1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
